// File: rtl/rx_frame_ctrl.sv
// Serial frame receiver: SOF 0xA5, LEN, payload, XOR checksum.
// Holds one checked frame in a 16-byte buffer until the consumer accepts it.
module rx_frame_ctrl #(
  parameter int MAX_LEN   = 16,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 frm_ready,
  input  logic [3:0]           rd_addr,
  output logic                 frm_valid,
  output logic [4:0]           frm_len,
  output logic [7:0]           rd_data,
  output logic                 chk_err,
  output logic                 len_err,
  output logic                 tout_err,
  output logic                 ovr_err,
  output logic [7:0]           frm_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_LEN = 3'd1,
    GET_PAY = 3'd2,
    GET_CHK = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t               state_q, state_d;
  logic [4:0]           len_q, len_d;
  logic [4:0]           idx_q, idx_d;
  logic [7:0]           xor_q, xor_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic [TIMEOUT_W-1:0] tcnt_inc_s;
  logic                 tout_hit_s;
  logic [7:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 chk_q, chk_d;
  logic                 lenerr_q, lenerr_d;
  logic                 tout_q, tout_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           buf_q [0:15];
  logic [7:0]           buf_d [0:15];

  // Saturating increment and timeout detection: the increment landing on timeout_cycles fires
  always_comb begin
    if (tcnt_q == {TIMEOUT_W{1'b1}}) begin
      tcnt_inc_s = tcnt_q;
    end else begin
      tcnt_inc_s = tcnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
    tout_hit_s = (timeout_cycles != {TIMEOUT_W{1'b0}}) && (tcnt_inc_s == timeout_cycles);
  end

  // Next-state, datapath and error-pulse logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    tcnt_d   = tcnt_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    chk_d    = 1'b0;
    lenerr_d = 1'b0;
    tout_d   = 1'b0;
    ovr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = {TIMEOUT_W{1'b0}};
        if (byte_valid && (byte_data == SOF_BYTE)) begin
          state_d = GET_LEN;
        end else begin
          state_d = IDLE;
        end
      end
      GET_LEN: begin
        if (byte_valid) begin
          tcnt_d = {TIMEOUT_W{1'b0}};
          if ((byte_data == 8'd0) || (byte_data > 8'(MAX_LEN))) begin
            lenerr_d = 1'b1;
            state_d  = IDLE;
          end else begin
            len_d   = byte_data[4:0];
            idx_d   = 5'd0;
            xor_d   = byte_data;
            state_d = GET_PAY;
          end
        end else if (tout_hit_s) begin
          tout_d  = 1'b1;
          tcnt_d  = {TIMEOUT_W{1'b0}};
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_inc_s;
        end
      end
      GET_PAY: begin
        if (byte_valid) begin
          tcnt_d             = {TIMEOUT_W{1'b0}};
          buf_d[idx_q[3:0]]  = byte_data;
          idx_d              = idx_q + 5'd1;
          xor_d              = chk_step(xor_q, byte_data);
          if ((idx_q + 5'd1) == len_q) begin
            state_d = GET_CHK;
          end else begin
            state_d = GET_PAY;
          end
        end else if (tout_hit_s) begin
          tout_d  = 1'b1;
          tcnt_d  = {TIMEOUT_W{1'b0}};
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_inc_s;
        end
      end
      GET_CHK: begin
        if (byte_valid) begin
          tcnt_d = {TIMEOUT_W{1'b0}};
          if (byte_data == xor_q) begin
            state_d = HOLD;
          end else begin
            chk_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (tout_hit_s) begin
          tout_d  = 1'b1;
          tcnt_d  = {TIMEOUT_W{1'b0}};
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_inc_s;
        end
      end
      HOLD: begin
        // Bytes arriving while a frame is held are dropped, even on the handshake cycle
        tcnt_d = {TIMEOUT_W{1'b0}};
        ovr_d  = byte_valid;
        if (frm_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        tcnt_d  = {TIMEOUT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == HOLD);
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= 5'd0;
      idx_q    <= 5'd0;
      xor_q    <= 8'd0;
      tcnt_q   <= {TIMEOUT_W{1'b0}};
      cnt_q    <= 8'd0;
      valid_q  <= 1'b0;
      chk_q    <= 1'b0;
      lenerr_q <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      xor_q    <= xor_d;
      tcnt_q   <= tcnt_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      chk_q    <= chk_d;
      lenerr_q <= lenerr_d;
      tout_q   <= tout_d;
      ovr_q    <= ovr_d;
    end
  end

  // Payload buffer keeps its contents across reset and between frames
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      buf_q[i] <= buf_d[i];
    end
  end

  assign frm_valid = valid_q;
  assign frm_len   = len_q;
  assign rd_data   = buf_q[rd_addr];
  assign chk_err   = chk_q;
  assign len_err   = lenerr_q;
  assign tout_err  = tout_q;
  assign ovr_err   = ovr_q;
  assign frm_cnt   = cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed self-checking bench for rx_frame_ctrl.
module tb_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] timeout_cycles;
  logic        frm_ready;
  logic [3:0]  rd_addr;
  logic        frm_valid;
  logic [4:0]  frm_len;
  logic [7:0]  rd_data;
  logic        chk_err, len_err, tout_err, ovr_err;
  logic [7:0]  frm_cnt;

  int passed = 0;
  int total  = 0;
  int chk_n = 0, len_n = 0, tout_n = 0, ovr_n = 0;

  rx_frame_ctrl #(.MAX_LEN(16), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .timeout_cycles(timeout_cycles), .frm_ready(frm_ready), .rd_addr(rd_addr),
    .frm_valid(frm_valid), .frm_len(frm_len), .rd_data(rd_data),
    .chk_err(chk_err), .len_err(len_err), .tout_err(tout_err), .ovr_err(ovr_err),
    .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_err)  chk_n++;
    if (len_err)  len_n++;
    if (tout_err) tout_n++;
    if (ovr_err)  ovr_n++;
  end

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    frm_ready = 1'b1;
    @(posedge clk); #1;
    frm_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; timeout_cycles = 16'd0;
    frm_ready = 1'b0; rd_addr = 4'd0;
    idle(3);
    total++; if (frm_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", frm_valid); else passed++;
    total++; if (frm_len !== 5'd0) $display("FAIL reset_len: got %0d want 0", frm_len); else passed++;
    total++; if (frm_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", frm_cnt); else passed++;
    total++; if ({chk_err, len_err, tout_err, ovr_err} !== 4'b0000)
      $display("FAIL reset_errs: got %b want 0000", {chk_err, len_err, tout_err, ovr_err}); else passed++;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    total++; if (frm_valid !== 1'b0) $display("FAIL good_early_valid: got %b want 0", frm_valid); else passed++;
    send_byte(8'h03);
    total++; if (frm_valid !== 1'b1) $display("FAIL good_valid: got %b want 1", frm_valid); else passed++;
    total++; if (frm_len !== 5'd3) $display("FAIL good_len: got %0d want 3", frm_len); else passed++;
    rd_addr = 4'd0; #1;
    total++; if (rd_data !== 8'h11) $display("FAIL good_rd0: got %h want 11", rd_data); else passed++;
    rd_addr = 4'd1; #1;
    total++; if (rd_data !== 8'h22) $display("FAIL good_rd1: got %h want 22", rd_data); else passed++;
    rd_addr = 4'd2; #1;
    total++; if (rd_data !== 8'h33) $display("FAIL good_rd2: got %h want 33", rd_data); else passed++;
    idle(3);
    total++; if (frm_valid !== 1'b1) $display("FAIL good_hold: got %b want 1", frm_valid); else passed++;
    handshake();
    total++; if (frm_valid !== 1'b0) $display("FAIL good_release: got %b want 0", frm_valid); else passed++;
    total++; if (frm_cnt !== 8'd1) $display("FAIL good_cnt: got %0d want 1", frm_cnt); else passed++;
  endtask

  task automatic test_chk_err();
    int c0;
    c0 = chk_n;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    total++; if (chk_err !== 1'b1) $display("FAIL chk_pulse: got %b want 1", chk_err); else passed++;
    total++; if (frm_valid !== 1'b0) $display("FAIL chk_valid: got %b want 0", frm_valid); else passed++;
    idle(2);
    total++; if (chk_n - c0 !== 1) $display("FAIL chk_count: got %0d want 1", chk_n - c0); else passed++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    rd_addr = 4'd0; #1;
    total++; if (frm_valid !== 1'b1) $display("FAIL chk_next_valid: got %b want 1", frm_valid); else passed++;
    total++; if (rd_data !== 8'h7E) $display("FAIL chk_next_rd0: got %h want 7e", rd_data); else passed++;
    handshake();
    total++; if (frm_cnt !== 8'd2) $display("FAIL chk_next_cnt: got %0d want 2", frm_cnt); else passed++;
  endtask

  task automatic test_len_err();
    int l0;
    logic [7:0] x;
    l0 = len_n;
    send_byte(8'hA5); send_byte(8'h00);
    total++; if (len_err !== 1'b1) $display("FAIL len_zero: got %b want 1", len_err); else passed++;
    send_byte(8'hA5); send_byte(8'h11);
    total++; if (len_err !== 1'b1) $display("FAIL len_17: got %b want 1", len_err); else passed++;
    send_byte(8'h33);
    idle(2);
    total++; if (len_n - l0 !== 2) $display("FAIL len_count: got %0d want 2", len_n - l0); else passed++;
    total++; if (frm_valid !== 1'b0) $display("FAIL len_valid: got %b want 0", frm_valid); else passed++;
    send_byte(8'hA5); send_byte(8'h10);
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h40 + 8'(i));
      x = x ^ (8'h40 + 8'(i));
    end
    send_byte(x);
    rd_addr = 4'd15; #1;
    total++; if (frm_valid !== 1'b1 || frm_len !== 5'd16)
      $display("FAIL len_max: got valid=%b len=%0d want valid=1 len=16", frm_valid, frm_len); else passed++;
    total++; if (rd_data !== 8'h4F) $display("FAIL len_max_rd15: got %h want 4f", rd_data); else passed++;
    handshake();
    total++; if (frm_cnt !== 8'd3) $display("FAIL len_max_cnt: got %0d want 3", frm_cnt); else passed++;
  endtask

  task automatic test_timeout();
    int t0;
    int n;
    timeout_cycles = 16'd20;
    t0 = tout_n;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (n == 0 && tout_err === 1'b1) n = i;
    end
    total++; if (n !== 20) $display("FAIL tout_delay: got %0d want 20", n); else passed++;
    total++; if (tout_n - t0 !== 1) $display("FAIL tout_count: got %0d want 1", tout_n - t0); else passed++;
    // A byte on the very cycle the counter would expire keeps the frame alive
    t0 = tout_n;
    send_byte(8'hA5); send_byte(8'h02); idle(19);
    send_byte(8'h05); idle(19);
    send_byte(8'h06); idle(19);
    send_byte(8'h01);
    total++; if (frm_valid !== 1'b1 || tout_n !== t0)
      $display("FAIL tout_edge: got valid=%b touts=%0d want valid=1 touts=0", frm_valid, tout_n - t0); else passed++;
    handshake();
    timeout_cycles = 16'd0;
    t0 = tout_n;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    idle(100);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    total++; if (frm_valid !== 1'b1) $display("FAIL tout_disabled_valid: got %b want 1", frm_valid); else passed++;
    timeout_cycles = 16'd5;
    idle(20);
    total++; if (frm_valid !== 1'b1 || tout_n !== t0)
      $display("FAIL tout_hold: got valid=%b touts=%0d want valid=1 touts=0", frm_valid, tout_n - t0); else passed++;
    handshake();
    idle(20);
    total++; if (tout_n !== t0) $display("FAIL tout_idle: got %0d want 0", tout_n - t0); else passed++;
    total++; if (frm_cnt !== 8'd5) $display("FAIL tout_cnt: got %0d want 5", frm_cnt); else passed++;
    timeout_cycles = 16'd0;
  endtask

  task automatic test_overrun();
    int l0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h13);
    total++; if (frm_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", frm_valid); else passed++;
    send_byte(8'h55);
    total++; if (ovr_err !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", ovr_err); else passed++;
    rd_addr = 4'd0; #1;
    total++; if (frm_valid !== 1'b1 || frm_len !== 5'd2 || rd_data !== 8'hAA)
      $display("FAIL ovr_held0: got valid=%b len=%0d rd=%h want 1 2 aa", frm_valid, frm_len, rd_data); else passed++;
    rd_addr = 4'd1; #1;
    total++; if (rd_data !== 8'hBB) $display("FAIL ovr_held1: got %h want bb", rd_data); else passed++;
    l0 = len_n;
    byte_valid = 1'b1; byte_data = 8'hA5; frm_ready = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0; frm_ready = 1'b0;
    total++; if (ovr_err !== 1'b1 || frm_valid !== 1'b0 || frm_cnt !== 8'd6)
      $display("FAIL ovr_coinc: got ovr=%b valid=%b cnt=%0d want 1 0 6", ovr_err, frm_valid, frm_cnt); else passed++;
    send_byte(8'h00);
    idle(1);
    total++; if (len_n !== l0) $display("FAIL ovr_dropped_sof: got %0d want 0", len_n - l0); else passed++;
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = chk_n + len_n + tout_n + ovr_n;
    timeout_cycles = 16'd3;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(10);
    total++; if (chk_n + len_n + tout_n + ovr_n !== e0)
      $display("FAIL rstmid_errs: got %0d want 0", chk_n + len_n + tout_n + ovr_n - e0); else passed++;
    total++; if (frm_cnt !== 8'd0 || frm_valid !== 1'b0)
      $display("FAIL rstmid_state: got cnt=%0d valid=%b want 0 0", frm_cnt, frm_valid); else passed++;
    timeout_cycles = 16'd0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    rd_addr = 4'd0; #1;
    total++; if (frm_valid !== 1'b1 || rd_data !== 8'h5A)
      $display("FAIL rstmid_next: got valid=%b rd=%h want 1 5a", frm_valid, rd_data); else passed++;
    handshake();
    total++; if (frm_cnt !== 8'd1) $display("FAIL rstmid_cnt: got %0d want 1", frm_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_chk_err();
    test_len_err();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
